// File: rtl/done_tracker_if.sv
// Signal bundle between the datapath done sources / control FSM and done_tracker.
// With DONE_TRK_MASK_EN defined the bundle also carries the per-channel ch_mask.
interface done_tracker_if #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 6,
   parameter int TMO_W = 16
);
   logic             arm;
   logic [N_CH-1:0]  done_in;
   logic [N_CH-1:0]  clear_in;
   logic             clear_all;
   logic [TMO_W-1:0] timeout_val;
`ifdef DONE_TRK_MASK_EN
   logic [N_CH-1:0]  ch_mask;
`endif
   logic [N_CH-1:0]  sticky;
   logic             all_done;
   logic             any_done;
   logic             busy;
   logic [CNT_W-1:0] done_cnt;
   logic             timeout_err;

   modport master (
`ifdef DONE_TRK_MASK_EN
      output ch_mask,
`endif
      output arm, done_in, clear_in, clear_all, timeout_val,
      input  sticky, all_done, any_done, busy, done_cnt, timeout_err
   );

   modport slave (
`ifdef DONE_TRK_MASK_EN
      input  ch_mask,
`endif
      input  arm, done_in, clear_in, clear_all, timeout_val,
      output sticky, all_done, any_done, busy, done_cnt, timeout_err
   );
endinterface

// File: rtl/done_tracker.sv
// Multi-channel sticky done tracker: done_in -> sticky/all_done one edge later, all outputs registered; no backpressure.
// Optional DONE_TRK_MASK_EN adds a ch_mask sampled at arm; masked channels count as done but never set or count.
module done_tracker #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 6,
   parameter int TMO_W = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   done_tracker_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT     = 2'd1,
      S_COMPLETE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [N_CH-1:0]  sticky_q, sticky_d;
   logic             all_done_q, all_done_d;
   logic             any_done_q, any_done_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TMO_W-1:0] timer_q, timer_d;
   logic [N_CH-1:0]  trk_mask;

`ifdef DONE_TRK_MASK_EN
   logic [N_CH-1:0]  mask_q, mask_d;
   assign trk_mask = mask_q;
`else
   assign trk_mask = '0;
`endif

   // Clear beats done on the same channel; masked channels never set.
   logic [N_CH-1:0]  sticky_wait;
   logic [N_CH-1:0]  new_ev;
   logic             complete_wait;
   logic             tmo_hit;
   logic [5:0]       pop;
   logic [CNT_W+5:0] cnt_sum;
   logic [CNT_W-1:0] cnt_sat;

   assign sticky_wait   = (sticky_q & ~bus.clear_in) | (bus.done_in & ~bus.clear_in & ~trk_mask);
   assign new_ev        = bus.done_in & ~sticky_q & ~bus.clear_in & ~trk_mask;
   assign complete_wait = &(sticky_wait | trk_mask);
   assign tmo_hit       = (bus.timeout_val != '0) && (timer_q == (bus.timeout_val - TMO_W'(1)));

   always_comb begin
      pop = '0;
      for (int i = 0; i < N_CH; i++) begin
         pop = pop + {5'd0, new_ev[i]};
      end
   end

   assign cnt_sum = {6'd0, cnt_q} + {{CNT_W{1'b0}}, pop};
   assign cnt_sat = (cnt_sum > {6'd0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

   always_comb begin
      state_d  = state_q;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      timer_d  = timer_q;
      err_d    = err_q;
`ifdef DONE_TRK_MASK_EN
      mask_d   = mask_q;
`endif
      if (bus.arm) begin
         state_d  = S_WAIT;
         sticky_d = '0;
         cnt_d    = '0;
         timer_d  = '0;
         err_d    = 1'b0;
`ifdef DONE_TRK_MASK_EN
         mask_d   = bus.ch_mask;
         if (&bus.ch_mask) begin
            state_d = S_COMPLETE;
         end
`endif
      end else begin
         case (state_q)
            S_WAIT: begin
               sticky_d = sticky_wait;
               cnt_d    = cnt_sat;
               timer_d  = timer_q + TMO_W'(1);
               // Completion on the timeout edge wins; flags are kept after a timeout for debug.
               if (complete_wait) begin
                  state_d = S_COMPLETE;
               end else if (tmo_hit) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
            S_COMPLETE: begin
               if (bus.clear_all) begin
                  sticky_d = '0;
                  state_d  = S_IDLE;
               end else if (|bus.clear_in) begin
                  sticky_d = sticky_q & ~bus.clear_in;
                  timer_d  = '0;
                  state_d  = S_WAIT;
               end
            end
            S_IDLE: ;
            default: state_d = S_IDLE;
         endcase
      end
      all_done_d = (state_d == S_COMPLETE);
      any_done_d = |sticky_d;
      busy_d     = (state_d == S_WAIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         sticky_q   <= '0;
         all_done_q <= 1'b0;
         any_done_q <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
         timer_q    <= '0;
      end else begin
         state_q    <= state_d;
         sticky_q   <= sticky_d;
         all_done_q <= all_done_d;
         any_done_q <= any_done_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
         timer_q    <= timer_d;
      end
   end

`ifdef DONE_TRK_MASK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q <= '0;
      end else begin
         mask_q <= mask_d;
      end
   end
`endif

   assign bus.sticky      = sticky_q;
   assign bus.all_done    = all_done_q;
   assign bus.any_done    = any_done_q;
   assign bus.busy        = busy_q;
   assign bus.done_cnt    = cnt_q;
   assign bus.timeout_err = err_q;

endmodule

// File: doc/done_tracker.md
Name: done_tracker

Overview:
- Parametrised multi-channel successor to the single sticky done flag.
- Captures done pulses from N_CH datapath units (quantisers, write-back engines, ...) into per-channel sticky flags.
- Aggregates the flags into a registered all-done indication for the control FSM, counts completion events, and runs a watchdog timeout per armed operation.
- Sits between the datapath units and the top-level control FSM.

Parameters:
- N_CH, 4: number of tracked channels (1..32).
- CNT_W, 6: width of the completion event counter (saturating).
- TMO_W, 16: width of the watchdog timer and of timeout_val.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  start new operation: clear flags, counter and timer; enter WAIT.
- done_in  in  N_CH  per-channel done pulse (level accepted; each cycle sampled).
- clear_in  in  N_CH  per-channel sticky clear.
- clear_all  in  1  write-back finished: release COMPLETE, clear all flags.
- timeout_val  in  TMO_W  watchdog limit in cycles; 0 disables the watchdog.
- sticky  out  N_CH  per-channel sticky done flags.
- all_done  out  1  every channel flagged (registered).
- any_done  out  1  OR of sticky (registered).
- busy  out  1  high in WAIT.
- done_cnt  out  CNT_W  number of 0->1 sticky transitions since arm, saturating at 2^CNT_W-1.
- timeout_err  out  1  sticky watchdog error, cleared only by arm or reset.

Behaviour:
- Reset, asynchronous on rst_n low: state IDLE; sticky=0, all_done=0, any_done=0, busy=0, done_cnt=0, timeout_err=0, timer=0. Reset mid-operation aborts immediately to these values.
- FSM states: IDLE, WAIT, COMPLETE. All outputs are registered.
- IDLE:
  - done_in and clear_in are ignored.
  - arm -> WAIT: sticky=0, done_cnt=0, timer=0, timeout_err=0.
- WAIT (busy=1):
  - Per channel i: clear_in[i] has priority and forces sticky[i]=0; otherwise done_in[i] sets sticky[i]=1.
  - Latency: done_in at edge t gives sticky visible after edge t+1.
  - done_cnt += popcount(done_in & ~sticky & ~clear_in), saturating.
  - all_done uses the next-state flags. When the last flag sets at edge t+1, all_done=1 and state=COMPLETE on that same edge.
- Timer (WAIT only):
  - Increments every cycle in WAIT; timeout_val=0 disables it.
  - Timeout: the timer reaches timeout_val-1 and completion is not occurring that cycle -> timeout_err=1, state=IDLE, busy=0, sticky retained for debug.
  - Completion on the same edge as the timeout beats the timeout.
- COMPLETE (all_done=1, busy=0):
  - done_in is ignored.
  - clear_all -> IDLE: sticky=0, all_done=0. done_cnt is retained until the next arm.
  - Any clear_in[i] without clear_all -> clears those bits, all_done=0, back to WAIT with timer=0.
- arm from any state restarts the operation and has priority over clear_all, clear_in and done_in in the same cycle.
- N_CH=1 degenerates to the single sticky flag plus counter and watchdog.

Optional Feature:
- Macro: DONE_TRK_MASK_EN.
- When defined:
  - Adds input ch_mask [N_CH], sampled at arm and held internally.
  - Masked channels (bit=1) never set sticky and do not count.
  - Masked channels are treated as done for all_done.
  - An arm with every channel masked enters COMPLETE on the next edge with done_cnt=0.
- When undefined: no port; all channels are tracked.

Test Plan:
- Reset: N_CH=4, assert rst_n low mid-WAIT with sticky=4'b0101 -> all outputs 0 and state IDLE asynchronously; done_in in IDLE stays ignored.
- Staggered completion: arm, then done_in = 0001, 0100, 0010, 1000 on cycles 2,3,5,7 -> sticky accumulates; all_done=1 and busy=0 exactly one edge after cycle 7; done_cnt=4; clear_all -> sticky=0 and all_done=0.
- Simultaneous clear/done: in WAIT, done_in[2]=1 and clear_in[2]=1 on the same cycle -> sticky[2]=0, done_cnt unchanged. Repeated done_in[0] held 5 cycles -> done_cnt +1 only.
- Watchdog: timeout_val=10, only 3 channels complete -> timeout_err=1 at 10th WAIT edge, state IDLE, sticky=0111. Next arm clears timeout_err. Case where last done lands on the timeout edge -> all_done=1, timeout_err=0.
- Priority and saturation: CNT_W=2 with 4 done events -> done_cnt=3. In COMPLETE, arm with clear_all together -> WAIT with sticky cleared. clear_in[1] alone in COMPLETE -> WAIT, all_done=0.
- DONE_TRK_MASK_EN: ch_mask=1010 at arm, done_in 0001 then 0100 -> all_done after second event, done_cnt=2. ch_mask=1111 -> COMPLETE one edge after arm.
